// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard/flush controller: FSM states,
// register-number helpers and the packed control-output bundle.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hzd_state_t;

    typedef logic [4:0] regbits_t;

    localparam regbits_t REG_ZERO = 5'd0;

    // Field order is the order the pipeline register interface lists them.
    typedef struct packed {
        logic pc_en;
        logic if_en;
        logic id_en;
        logic ex_en;
        logic mem_en;
        logic if_flush;
        logic id_flush;
        logic ex_flush;
        logic mem_flush;
        logic halt;
    } ctrl_t;

    // $zero is hardwired, so a write to it can never create a dependency.
    function automatic logic reg_match(input regbits_t dst, input regbits_t src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_flush_ctrl_hazard_detect.sv
// Load-use detector: a load in ID/EX whose destination feeds the
// instruction currently in IF/ID.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_dread,
    input  regbits_t ex_wsel,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rt,
    output logic     stall
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = reg_match(ex_wsel, id_rs);
    assign rt_hit = id_uses_rt && reg_match(ex_wsel, id_rt);
    assign stall  = ex_dread && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline (RUN/DWAIT/HALTED).
// Define HAZARD_PERF_CNT_EN to add the perf_stall/perf_flush/perf_dwait counters.
module hazard_flush_ctrl
    import cpu_types_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dread,
    input  logic       mem_dwrite,
    input  logic       ex_dread,
    input  regbits_t   ex_wsel,
    input  regbits_t   id_rs,
    input  regbits_t   id_rt,
    input  logic       id_uses_rt,
    input  logic       id_jump,
    input  logic       mem_redirect,
    input  logic       wb_halt,
    output logic       pc_en,
    output logic       IF_EN,
    output logic       ID_EN,
    output logic       EX_EN,
    output logic       MEM_EN,
    output logic       IF_FLUSH,
    output logic       ID_FLUSH,
    output logic       EX_FLUSH,
    output logic       MEM_FLUSH,
    output logic       halt,
    output hzd_state_t dbg_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush,
    output logic [PERF_W-1:0] perf_dwait
`endif
);

    hzd_state_t state;
    hzd_state_t next_state;
    ctrl_t      flow;
    ctrl_t      ctrl;
    logic       load_use;
    logic       dmem_wait;
    logic       use_flow;

    if (PERF_W < 1) begin : g_perf_w_invalid
    end

    hazard_detect u_detect (
        .ex_dread   (ex_dread),
        .ex_wsel    (ex_wsel),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .stall      (load_use)
    );

    assign dmem_wait = (mem_dread || mem_dwrite) && !dhit;

    // Normal-flow priority once no data access is pending:
    // redirect > load-use > icache miss > jump > advance.
    always_comb begin
        flow = '0;
        if (mem_redirect) begin
            flow.pc_en    = 1'b1;
            flow.if_en    = 1'b1;
            flow.id_en    = 1'b1;
            flow.ex_en    = 1'b1;
            flow.mem_en   = 1'b1;
            flow.if_flush = 1'b1;
            flow.id_flush = 1'b1;
            flow.ex_flush = 1'b1;
        end else if (load_use) begin
            flow.id_en    = 1'b1;
            flow.ex_en    = 1'b1;
            flow.mem_en   = 1'b1;
            flow.id_flush = 1'b1;
        end else if (!ihit) begin
            flow.if_en    = 1'b1;
            flow.id_en    = 1'b1;
            flow.ex_en    = 1'b1;
            flow.mem_en   = 1'b1;
            flow.if_flush = 1'b1;
        end else begin
            flow.pc_en    = 1'b1;
            flow.if_en    = 1'b1;
            flow.id_en    = 1'b1;
            flow.ex_en    = 1'b1;
            flow.mem_en   = 1'b1;
            flow.if_flush = id_jump;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // On the wb_halt cycle everything freezes; the halt writeback commits
    // at that edge and nothing younger is allowed to move behind it.
    always_comb begin
        ctrl       = '0;
        next_state = state;
        use_flow   = 1'b0;
        case (state)
            RUN: begin
                if (wb_halt) begin
                    next_state = HALTED;
                end else if (dmem_wait) begin
                    next_state = DWAIT;
                end else begin
                    use_flow = 1'b1;
                end
            end
            DWAIT: begin
                if (wb_halt) begin
                    next_state = HALTED;
                end else if (dhit) begin
                    next_state = RUN;
                    if (ihit) begin
                        use_flow = 1'b1;
                    end else begin
                        ctrl.mem_en   = 1'b1;
                        ctrl.ex_flush = 1'b1;
                    end
                end
            end
            HALTED: begin
                ctrl.halt = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase
        if (use_flow) begin
            ctrl = flow;
        end
        if (!nRST) begin
            ctrl           = '0;
            ctrl.if_flush  = 1'b1;
            ctrl.id_flush  = 1'b1;
            ctrl.ex_flush  = 1'b1;
            ctrl.mem_flush = 1'b1;
        end
    end

    assign pc_en     = ctrl.pc_en;
    assign IF_EN     = ctrl.if_en;
    assign ID_EN     = ctrl.id_en;
    assign EX_EN     = ctrl.ex_en;
    assign MEM_EN    = ctrl.mem_en;
    assign IF_FLUSH  = ctrl.if_flush;
    assign ID_FLUSH  = ctrl.id_flush;
    assign EX_FLUSH  = ctrl.ex_flush;
    assign MEM_FLUSH = ctrl.mem_flush;
    assign halt      = ctrl.halt;
    assign dbg_state = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_events;
    logic [PERF_W-1:0] dwait_cycles;
    logic              flush_event;

    // A jump only counts when it actually steers fetch, not when shadowed.
    assign flush_event = use_flow && (mem_redirect || (id_jump && ihit && !load_use));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_events <= '0;
            dwait_cycles <= '0;
        end else begin
            if (!ctrl.pc_en && (state != HALTED) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (flush_event && (flush_events != '1)) begin
                flush_events <= flush_events + PERF_W'(1);
            end
            if ((state == DWAIT) && (dwait_cycles != '1)) begin
                dwait_cycles <= dwait_cycles + PERF_W'(1);
            end
        end
    end

    assign perf_stall = stall_cycles;
    assign perf_flush = flush_events;
    assign perf_dwait = dwait_cycles;
`endif

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Stall/flush controller for the 5-stage pipelined MIPS core. It drives every enable and flush input of the pipeline register interface (IF_EN..MEM_EN, IF_FLUSH..MEM_FLUSH, halt), plus the PC enable.
- It resolves icache misses, dcache waits, load-use hazards, ID-stage jumps, MEM-stage branch/JR redirects and halt.
- It sits beside the pipeline register block. It reads hazard-relevant fields from the pipeline registers and hit signals from the caches.

Parameters:
- PERF_W, 32, width of the optional performance counters.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  icache delivers the instruction this cycle.
- dhit  in  1  dcache completes the outstanding data access this cycle.
- mem_dread  in  1  EX/MEM stage holds a load (EX_dread).
- mem_dwrite  in  1  EX/MEM stage holds a store (EX_dwrite).
- ex_dread  in  1  ID/EX stage holds a load (ID_dread).
- ex_wsel  in  5  destination register of the ID/EX instruction.
- id_rs  in  5  rs field of the IF/ID instruction.
- id_rt  in  5  rt field of the IF/ID instruction.
- id_uses_rt  in  1  IF/ID instruction reads rt.
- id_jump  in  1  J/JAL decoded in ID.
- mem_redirect  in  1  taken BEQ/BNE or JR resolved in the EX/MEM stage.
- wb_halt  in  1  halt instruction reached MEM/WB (MEM_halt).
- pc_en  out  1  PC register update.
- IF_EN, ID_EN, EX_EN, MEM_EN  out  1 each  register advance enables.
- IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH  out  1 each  load a bubble (all zero) at the next edge. Flush has precedence over EN.
- halt  out  1  sticky processor halt.

Behaviour:
FSM states: RUN, DWAIT, HALTED. All outputs are combinational from state and inputs.

Reset (nRST low, asynchronous):
- State goes to RUN.
- While nRST is low, all EN=0, all FLUSH=1, pc_en=0, halt=0.

HALTED:
- Entered from any state when wb_halt=1; that edge commits the halt writeback.
- Exit only via reset.
- Outputs: halt=1, all EN=0, all FLUSH=0, pc_en=0. All other inputs are ignored.

RUN, priority descending:
1. mem_dread|mem_dwrite with dhit=0: go to DWAIT. Freeze everything: all EN=0, pc_en=0.
2. mem_redirect: IF_FLUSH=ID_FLUSH=EX_FLUSH=1 (EX/MEM gets a bubble). MEM_EN=1, pc_en=1 (PC takes the redirect target). The redirect is taken even if ihit=0.
3. Load-use: ex_dread and ex_wsel!=0 and (ex_wsel==id_rs or (id_uses_rt and ex_wsel==id_rt)). Then pc_en=0, IF_EN=0, ID_FLUSH=1, EX_EN=MEM_EN=1. Exactly one bubble per hazard, because the next cycle the load is no longer in ID/EX.
4. ihit=0: pc_en=0, IF_FLUSH=1 (bubble into IF/ID), ID_EN=EX_EN=MEM_EN=1.
5. id_jump with ihit=1: IF_FLUSH=1, pc_en=1, all other EN=1.
6. Otherwise: all EN=1, pc_en=1, all FLUSH=0.

Memory access completing in RUN (dhit=1 same cycle): treated as normal flow; continue down the priority list.

DWAIT:
- Hold all EN=0 and pc_en=0 until dhit=1.
- On dhit=1 with ihit=1: full advance, same as RUN rules 2–6, then return to RUN.
- On dhit=1 with ihit=0: MEM_EN=1, EX_FLUSH=1, IF/ID and ID/EX held, pc_en=0, return to RUN.
- A redirect or load-use seen while in DWAIT is deferred; it is re-evaluated in RUN.

Simultaneous events: wb_halt beats dmem wait, which beats redirect, load-use, imiss and jump.
- Register 0 never causes a load-use stall.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: three PERF_W counters, stall_cycles, flush_events and dwait_cycles, exported as outputs perf_stall, perf_flush and perf_dwait.
  - stall_cycles increments on any cycle with pc_en=0 while not HALTED.
  - flush_events increments on each redirect or jump.
  - dwait_cycles increments on each cycle in DWAIT.
  - Counters are cleared by reset, saturate at all-ones, and freeze in HALTED.
- Undefined: no counters and no extra ports.

Decomposition:
- cpu_types_pkg gets hzd_state_t (RUN, DWAIT, HALTED), a regbits_t comparison helper, and the REG_ZERO constant.
- One sub-module, hazard_detect: pure combinational load-use compare (ex_dread, ex_wsel, id_rs, id_rt, id_uses_rt -> stall).
- The FSM and output decode stay in hazard_flush_ctrl.

Test Plan:
1. Reset mid-DWAIT: pulse nRST low with mem_dread=1, dhit=0 -> state RUN; all FLUSH=1 during reset; all EN=1 on the first cycle after release with ihit=1.
2. Load-use: ex_dread=1, ex_wsel=8, id_rs=8, ihit=1 -> one cycle of pc_en=0, IF_EN=0, ID_FLUSH=1; the same case with ex_wsel=0 gives no stall.
3. Dcache wait: mem_dwrite=1, dhit=0 for 3 cycles, then dhit=1 with ihit=0 -> 3 frozen cycles, then MEM_EN=1, EX_FLUSH=1, pc_en=0, state RUN.
4. Redirect with coincident load-use and ihit=0 -> IF_FLUSH=ID_FLUSH=EX_FLUSH=1, pc_en=1, no IF_EN=0 stall.
5. Halt: wb_halt=1 while mem_dread=1, dhit=0 -> HALTED next edge, halt=1 held for 10 cycles regardless of inputs.
6. Jump: id_jump=1, ihit=1 -> IF_FLUSH=1, pc_en=1 for one cycle; id_jump=1, ihit=0 -> IF_FLUSH=1, pc_en=0 (jump re-seen later).
